exec_word_assembler: RTL and testbench

- Upstream neighbour of the execute-interface byte reorder stage.
- Collects a serial byte stream from the fetch/bus side into 40-bit (5-byte) words.
- Presents each word, with its per-word reorder enable, to the reorder stage under a valid/ready handshake.
- Tracks delivered-word count and partial-word status for the multi-cycle execute control logic.

---
 rtl/exec_word_assembler.sv | 162 ++++++++++++++++
 tb/tb_exec_word_assembler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_word_assembler.sv
// exec_word_assembler
// Packs a serial byte stream into BYTES-wide words, MSB-first in wire order,
// and offers each finished word (plus its latched reorder enable) downstream.
// Also keeps a wrapping count of delivered words and a partial-word flag.
//
// Handshake: a byte moves when controlInByteValid & controlOutByteReady are
// both high at a rising clk edge; a word moves when controlOutWordValid &
// controlInWordReady are both high at a rising clk edge. Valid never waits on
// ready. Byte ready depends combinationally on word ready and flush.
module exec_word_assembler #(
    parameter int BYTES  = 5,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BYTE_W-1:0]         dataInByte,
    input  logic                      controlInByteValid,
    output logic                      controlOutByteReady,
    input  logic                      controlInSwapMode,
    input  logic                      controlInFlush,
    output logic [BYTES*BYTE_W-1:0]   dataOutWord,
    output logic                      controlOutWordValid,
    input  logic                      controlInWordReady,
    output logic                      controlOutReorderEnable,
    output logic                      controlOutPartial,
    output logic [CNT_W-1:0]          dataOutWordCount
);

    localparam int WORD_W = BYTES * BYTE_W;
    localparam int IDX_W  = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               valid_q, valid_d;
    logic               reorder_q, reorder_d;
    logic               partial_q, partial_d;
    logic [CNT_W-1:0]   wcount_q, wcount_d;

    logic               byte_ready;
    logic               byte_fire;
    logic               word_fire;
    logic               lane_we;
    logic [IDX_W-1:0]   lane_idx;

    // Byte ready: open in COLLECT, only alongside a word hand-off in HOLD.
    always_comb begin
        byte_ready = 1'b0;
        if (state_q == ST_COLLECT) begin
            byte_ready = ~controlInFlush;
        end else begin
            byte_ready = controlInWordReady & ~controlInFlush;
        end
    end

    assign byte_fire = controlInByteValid & byte_ready;
    assign word_fire = valid_q & controlInWordReady;

    // Next-state logic: byte collection, word hand-off and flush priority.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        valid_d   = valid_q;
        reorder_d = reorder_q;
        wcount_d  = wcount_q;
        lane_we   = 1'b0;
        lane_idx  = '0;

        if (controlInFlush) begin
            // Flush beats a simultaneous word transfer: the word is not counted.
            state_d = ST_COLLECT;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (byte_fire) begin
                        lane_we  = 1'b1;
                        lane_idx = cnt_q;
                        if (cnt_q == '0) begin
                            reorder_d = controlInSwapMode;
                        end
                        if (cnt_q == LAST_IDX) begin
                            cnt_d   = '0;
                            valid_d = 1'b1;
                            state_d = ST_HOLD;
                        end else begin
                            cnt_d = cnt_q + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (word_fire) begin
                        wcount_d = wcount_q + CNT_W'(1);
                        valid_d  = 1'b0;
                        state_d  = ST_COLLECT;
                        if (byte_fire) begin
                            // Overlapped byte starts the next word for full throughput.
                            lane_we   = 1'b1;
                            lane_idx  = '0;
                            reorder_d = controlInSwapMode;
                            cnt_d     = IDX_W'(1);
                        end else begin
                            cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                end
            endcase
        end

        // Byte k lands in the k-th lane counted from the MSB end.
        for (int k = 0; k < BYTES; k++) begin
            if (lane_we && (lane_idx == IDX_W'(k))) begin
                word_d[(BYTES-1-k)*BYTE_W +: BYTE_W] = dataInByte;
            end
        end

        partial_d = (cnt_d != '0);
    end

    // State and output registers; reset discards any partial or held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            reorder_q <= 1'b0;
            partial_q <= 1'b0;
            wcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            reorder_q <= reorder_d;
            partial_q <= partial_d;
            wcount_q  <= wcount_d;
        end
    end

    assign controlOutByteReady     = byte_ready;
    assign dataOutWord             = word_q;
    assign controlOutWordValid     = valid_q;
    assign controlOutReorderEnable = reorder_q;
    assign controlOutPartial       = partial_q;
    assign dataOutWordCount        = wcount_q;

endmodule

// File: tb/tb_exec_word_assembler.sv
// Bench for exec_word_assembler: cycle table for the main flows, then
// hand-written sequences for counter wrap and mid-word reset.
module tb_exec_word_assembler;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        swap_mode;
    logic        flush;
    logic [39:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        reorder_en;
    logic        partial;
    logic [15:0] word_count;

    logic        s_byte_ready;
    logic [39:0] s_word_out;
    logic        s_word_valid;
    logic        s_reorder_en;
    logic        s_partial;
    logic [3:0]  s_word_count;

    int checks   = 0;
    int failures = 0;

    logic        sb_en = 1'b0;
    logic [40:0] exp_q[$];

    exec_word_assembler dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .dataInByte              (data_in),
        .controlInByteValid      (byte_valid),
        .controlOutByteReady     (byte_ready),
        .controlInSwapMode       (swap_mode),
        .controlInFlush          (flush),
        .dataOutWord             (word_out),
        .controlOutWordValid     (word_valid),
        .controlInWordReady      (word_ready),
        .controlOutReorderEnable (reorder_en),
        .controlOutPartial       (partial),
        .dataOutWordCount        (word_count)
    );

    // Narrow-counter instance sharing the same stimulus, so wrap is reachable quickly.
    exec_word_assembler #(.CNT_W(4)) dut_small (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .dataInByte              (data_in),
        .controlInByteValid      (byte_valid),
        .controlOutByteReady     (s_byte_ready),
        .controlInSwapMode       (swap_mode),
        .controlInFlush          (flush),
        .dataOutWord             (s_word_out),
        .controlOutWordValid     (s_word_valid),
        .controlInWordReady      (word_ready),
        .controlOutReorderEnable (s_reorder_en),
        .controlOutPartial       (s_partial),
        .dataOutWordCount        (s_word_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bv;
        logic [7:0]  d;
        logic        sw;
        logic        fl;
        logic        wr;
        logic        e_br;
        logic        e_wv;
        logic [39:0] e_word;
        logic        e_reo;
        logic        e_part;
        logic [15:0] e_wc;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(input logic bv, input logic [7:0] d, input logic sw,
                                input logic fl, input logic wr, input logic e_br,
                                input logic e_wv, input logic [39:0] e_word,
                                input logic e_reo, input logic e_part,
                                input logic [15:0] e_wc);
        vec_t v;
        v.bv = bv; v.d = d; v.sw = sw; v.fl = fl; v.wr = wr;
        v.e_br = e_br; v.e_wv = e_wv; v.e_word = e_word;
        v.e_reo = e_reo; v.e_part = e_part; v.e_wc = e_wc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs just after the rising edge.
    task automatic drive(input logic bv, input logic [7:0] d, input logic sw,
                         input logic fl, input logic wr);
        @(posedge clk);
        #1;
        byte_valid = bv;
        data_in    = d;
        swap_mode  = sw;
        flush      = fl;
        word_ready = wr;
    endtask

    // Stream one word back-to-back with word_ready held high.
    task automatic send_word(input logic [39:0] w, input logic sw);
        logic [39:0] tmp;
        tmp = w;
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, tmp[39-8*b -: 8], (b == 0) ? sw : 1'b0, 1'b0, 1'b1);
        end
    endtask

    // Scoreboard: compare every word hand-off against the expected queue.
    always @(negedge clk) begin
        if (sb_en && word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_word: got 0x%0h expected none", word_out);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                if ({reorder_en, word_out} !== e) begin
                    failures++;
                    $display("FAIL sb_word: got 0x%0h expected 0x%0h", {reorder_en, word_out}, e);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        data_in    = 8'h00;
        byte_valid = 1'b0;
        swap_mode  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;

        vecs[0]  = mk(1, 8'h11, 1, 0, 1,  1, 0, 40'h0, 0, 0, 16'd0);
        vecs[1]  = mk(1, 8'h22, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd0);
        vecs[2]  = mk(1, 8'h33, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd0);
        vecs[3]  = mk(1, 8'h44, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd0);
        vecs[4]  = mk(1, 8'h55, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd0);
        vecs[5]  = mk(0, 8'h00, 0, 0, 0,  0, 1, 40'h1122334455, 1, 0, 16'd0);
        vecs[6]  = mk(1, 8'h99, 0, 0, 0,  0, 1, 40'h1122334455, 1, 0, 16'd0);
        vecs[7]  = mk(1, 8'h99, 0, 0, 0,  0, 1, 40'h1122334455, 1, 0, 16'd0);
        vecs[8]  = mk(1, 8'h99, 0, 0, 0,  0, 1, 40'h1122334455, 1, 0, 16'd0);
        vecs[9]  = mk(0, 8'h00, 0, 0, 1,  1, 1, 40'h1122334455, 1, 0, 16'd0);
        vecs[10] = mk(0, 8'h00, 0, 0, 1,  1, 0, 40'h0, 0, 0, 16'd1);
        vecs[11] = mk(1, 8'hAA, 0, 0, 1,  1, 0, 40'h0, 0, 0, 16'd1);
        vecs[12] = mk(1, 8'hBB, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd1);
        vecs[13] = mk(1, 8'hCC, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd1);
        vecs[14] = mk(1, 8'hDD, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd1);
        vecs[15] = mk(1, 8'hEE, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd1);
        vecs[16] = mk(1, 8'h01, 1, 0, 1,  1, 1, 40'hAABBCCDDEE, 0, 0, 16'd1);
        vecs[17] = mk(1, 8'h02, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd2);
        vecs[18] = mk(1, 8'h03, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd2);
        vecs[19] = mk(1, 8'h04, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd2);
        vecs[20] = mk(1, 8'h05, 0, 0, 1,  1, 0, 40'h0, 0, 1, 16'd2);
        vecs[21] = mk(0, 8'h00, 0, 0, 1,  1, 1, 40'h0102030405, 1, 0, 16'd2);
        vecs[22] = mk(0, 8'h00, 0, 0, 0,  1, 0, 40'h0, 0, 0, 16'd3);
        vecs[23] = mk(1, 8'h77, 1, 0, 0,  1, 0, 40'h0, 0, 0, 16'd3);
        vecs[24] = mk(1, 8'h88, 0, 0, 0,  1, 0, 40'h0, 0, 1, 16'd3);
        vecs[25] = mk(1, 8'h99, 0, 0, 0,  1, 0, 40'h0, 0, 1, 16'd3);
        vecs[26] = mk(1, 8'hFF, 0, 1, 0,  0, 0, 40'h0, 0, 1, 16'd3);
        vecs[27] = mk(1, 8'h0A, 0, 0, 0,  1, 0, 40'h0, 0, 0, 16'd3);
        vecs[28] = mk(1, 8'h0B, 0, 0, 0,  1, 0, 40'h0, 0, 1, 16'd3);
        vecs[29] = mk(1, 8'h0C, 0, 0, 0,  1, 0, 40'h0, 0, 1, 16'd3);
        vecs[30] = mk(1, 8'h0D, 0, 0, 0,  1, 0, 40'h0, 0, 1, 16'd3);
        vecs[31] = mk(1, 8'h0E, 0, 0, 0,  1, 0, 40'h0, 0, 1, 16'd3);
        vecs[32] = mk(0, 8'h00, 0, 0, 0,  0, 1, 40'h0A0B0C0D0E, 0, 0, 16'd3);
        vecs[33] = mk(0, 8'h00, 0, 1, 1,  0, 1, 40'h0A0B0C0D0E, 0, 0, 16'd3);
        vecs[34] = mk(0, 8'h00, 0, 0, 1,  1, 0, 40'h0, 0, 0, 16'd3);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_word_valid", 64'(word_valid), 64'd0);
        check("rst_word", 64'(word_out), 64'd0);
        check("rst_reorder", 64'(reorder_en), 64'd0);
        check("rst_partial", 64'(partial), 64'd0);
        check("rst_count", 64'(word_count), 64'd0);
        check("rst_byte_ready", 64'(byte_ready), 64'd1);
        rst_n = 1'b1;

        // Table-driven cycles
        for (int i = 0; i < 35; i++) begin
            drive(vecs[i].bv, vecs[i].d, vecs[i].sw, vecs[i].fl, vecs[i].wr);
            #2;
            check($sformatf("v%0d_byte_ready", i), 64'(byte_ready), 64'(vecs[i].e_br));
            check($sformatf("v%0d_word_valid", i), 64'(word_valid), 64'(vecs[i].e_wv));
            check($sformatf("v%0d_partial", i), 64'(partial), 64'(vecs[i].e_part));
            check($sformatf("v%0d_count", i), 64'(word_count), 64'(vecs[i].e_wc));
            check($sformatf("v%0d_small_count", i), 64'(s_word_count), 64'(vecs[i].e_wc[3:0]));
            if (vecs[i].e_wv) begin
                check($sformatf("v%0d_word", i), 64'(word_out), 64'(vecs[i].e_word));
                check($sformatf("v%0d_reorder", i), 64'(reorder_en), 64'(vecs[i].e_reo));
            end
        end

        // Counter wrap: 13 more words at full throughput, scoreboarded.
        sb_en = 1'b1;
        for (int w = 0; w < 13; w++) begin
            logic [39:0] wv;
            logic        sw;
            wv = {8'(w*5+1), 8'(w*5+2), 8'(w*5+3), 8'(w*5+4), 8'(w*5+5)};
            sw = (w % 2) == 1;
            exp_q.push_back({sw, wv});
            send_word(wv, sw);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        #2;
        check("wrap_pre_valid", 64'(s_word_valid), 64'd1);
        check("wrap_pre_small_count", 64'(s_word_count), 64'd15);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        check("wrap_small_count", 64'(s_word_count), 64'd0);
        check("wrap_main_count", 64'(word_count), 64'h0010);
        check("wrap_valid_low", 64'(word_valid), 64'd0);
        sb_en = 1'b0;
        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);

        // Mid-word reset after two bytes
        drive(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'h5B, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        check("pre_rst_partial", 64'(partial), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(word_valid), 64'd0);
        check("mid_rst_word", 64'(word_out), 64'd0);
        check("mid_rst_reorder", 64'(reorder_en), 64'd0);
        check("mid_rst_partial", 64'(partial), 64'd0);
        check("mid_rst_count", 64'(word_count), 64'd0);
        check("mid_rst_small_count", 64'(s_word_count), 64'd0);
        #1;
        rst_n = 1'b1;
        send_word(40'hC1C2C3C4C5, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #2;
        check("post_rst_valid", 64'(word_valid), 64'd1);
        check("post_rst_word", 64'(word_out), 64'hC1C2C3C4C5);
        check("post_rst_reorder", 64'(reorder_en), 64'd0);
        check("post_rst_count", 64'(word_count), 64'd0);
        check("post_rst_partial", 64'(partial), 64'd0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
